// File: rtl/frequency_counter_multi_if.sv
// Measurement bus of frequency_counter_multi: measured inputs plus published
// per-channel results. Optional min/max tracking ports exist only when
// FREQ_CNT_MINMAX_EN is defined.
interface frequency_counter_multi_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32
);
    logic [N_CH-1:0]       f;
    logic [N_CH*CNT_W-1:0] freq;
    logic                  valid;
    logic [N_CH-1:0]       ovf;
    logic [N_CH-1:0]       alive;
`ifdef FREQ_CNT_MINMAX_EN
    logic                  clr_minmax;
    logic [N_CH*CNT_W-1:0] freq_min;
    logic [N_CH*CNT_W-1:0] freq_max;

    modport master (input f, clr_minmax, output freq, valid, ovf, alive, freq_min, freq_max);
    modport slave  (output f, clr_minmax, input freq, valid, ovf, alive, freq_min, freq_max);
`else
    modport master (input f, output freq, valid, ovf, alive);
    modport slave  (output f, input freq, valid, ovf, alive);
`endif
endinterface

// File: rtl/frequency_counter_multi.sv
// Multi-channel frequency meter. Each asynchronous input is synchronised,
// edge-detected and counted in the ref_clk domain over a common gate window
// of CLOCK_FREQ cycles; all channel results publish together with a
// one-cycle valid strobe, along with saturation (ovf) and activity (alive).
// Optional feature macro: FREQ_CNT_MINMAX_EN (per-channel min/max tracking).
module frequency_counter_multi #(
    parameter int unsigned N_CH       = 4,
    parameter logic [31:0] CLOCK_FREQ = 32'd100_000_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     ref_clk,
    input  logic                     reset,
    frequency_counter_multi_if.master bus
);
    (* async_reg = "true" *) logic [N_CH-1:0] sync_meta;
    (* async_reg = "true" *) logic [N_CH-1:0] sync_q;
    logic [N_CH-1:0]       dly_q;
    logic [N_CH-1:0]       edge_det;

    logic [31:0]           gate_cnt;
    logic                  term;

    logic [CNT_W-1:0]      cnt    [N_CH];
    logic [CNT_W-1:0]      result [N_CH];
    logic [N_CH-1:0]       sticky;
    logic [N_CH-1:0]       sat;
    logic [N_CH-1:0]       ovf_new;

    logic [N_CH*CNT_W-1:0] freq_r;
    logic [N_CH-1:0]       ovf_r;
    logic [N_CH-1:0]       alive_r;
    logic                  valid_r;

    // Two-stage synchroniser followed by a delay stage for edge detection
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            dly_q     <= '0;
        end else begin
            sync_meta <= bus.f;
            sync_q    <= sync_meta;
            dly_q     <= sync_q;
        end
    end

    assign edge_det = sync_q & ~dly_q;
    assign term     = (gate_cnt == CLOCK_FREQ - 32'd1);

    // Gate window counter, wraps after the terminal cycle
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (term) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 32'd1;
        end
    end

    // Per-channel saturating next count; the current-cycle edge is folded in
    // so an edge on the terminal cycle lands in the closing window
    always_comb begin
        sat     = '0;
        ovf_new = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sat[i]     = (cnt[i] == '1);
            result[i]  = (edge_det[i] && !sat[i]) ? cnt[i] + 1'b1 : cnt[i];
            ovf_new[i] = sticky[i] | (edge_det[i] & sat[i]);
        end
    end

    // Channel counters and publication of results at the window boundary
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            sticky  <= '0;
            freq_r  <= '0;
            ovf_r   <= '0;
            alive_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= term;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (term) begin
                    freq_r[i*CNT_W +: CNT_W] <= result[i];
                    ovf_r[i]                 <= ovf_new[i];
                    alive_r[i]               <= (result[i] != '0);
                    cnt[i]                   <= '0;
                    sticky[i]                <= 1'b0;
                end else begin
                    cnt[i]    <= result[i];
                    sticky[i] <= ovf_new[i];
                end
            end
        end
    end

    assign bus.freq  = freq_r;
    assign bus.ovf   = ovf_r;
    assign bus.alive = alive_r;
    assign bus.valid = valid_r;

`ifdef FREQ_CNT_MINMAX_EN
    logic [N_CH*CNT_W-1:0] min_r;
    logic [N_CH*CNT_W-1:0] max_r;

    // Running min/max per channel; a clear coinciding with publication
    // seeds both from the new result
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            min_r <= '1;
            max_r <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (term && bus.clr_minmax) begin
                    min_r[i*CNT_W +: CNT_W] <= result[i];
                    max_r[i*CNT_W +: CNT_W] <= result[i];
                end else if (term) begin
                    if (result[i] < min_r[i*CNT_W +: CNT_W]) begin
                        min_r[i*CNT_W +: CNT_W] <= result[i];
                    end
                    if (result[i] > max_r[i*CNT_W +: CNT_W]) begin
                        max_r[i*CNT_W +: CNT_W] <= result[i];
                    end
                end else if (bus.clr_minmax) begin
                    min_r[i*CNT_W +: CNT_W] <= '1;
                    max_r[i*CNT_W +: CNT_W] <= '0;
                end
            end
        end
    end

    assign bus.freq_min = min_r;
    assign bus.freq_max = max_r;
`endif
endmodule
